alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
Requester-side front end for the combinational alu. Accepts operation requests over a valid/ready handshake, drives the alu operands and mode from a register stage, and captures result and overflow into an output register. Returns results over a second valid/ready handshake, keeps a sticky overflow status and counts completions. Sits between the instruction decode/issue logic and the register-file writeback.

Parameters:
TAG_W, 4, width of the request tag carried alongside each operation
CNT_W, 8, width of the completed-operation counter
SATURATE, 0, 1 = clamp result to max/min signed value when overflow is set; 0 = wrapped result

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_a  in  `WORD_SIZE  signed operand a
in_b  in  `WORD_SIZE  signed operand b
in_mode  in  1  0 = ADD, 1 = SUB
in_tag  in  TAG_W  opaque tag, returned with the result
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_result  out  `WORD_SIZE  signed result
out_overflow  out  1  overflow for this result
out_tag  out  TAG_W  tag of this result
ovf_clr  in  1  synchronous clear of sticky_ovf
sticky_ovf  out  1  set by any overflowing result; held until cleared
op_count  out  CNT_W  number of completed output handshakes, wraps

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. On reset, every valid bit, sticky_ovf and op_count go to 0. out_result, out_overflow and out_tag also reset to 0. A reset mid-operation drops in-flight operations silently.
- Pipeline has two stages:
  - S1 registers a, b, mode and tag on accept.
  - The alu is fed from S1.
  - S2 registers the result, overflow and tag.
- Latency: a request accepted in cycle N gives out_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: one operation per cycle.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load. in_ready is combinational from state and out_ready and never depends on in_valid.
  - S1 gets a new entry on accept, clears on s2_load without a new accept, and holds otherwise.
  - S2 clears on an output handshake without s2_load.
- Backpressure:
  - While out_valid && !out_ready, all out_* outputs stay stable.
  - When both stages are full, in_ready=0.
  - No request is lost or duplicated.
- Arithmetic: results are `WORD_SIZE-bit two's complement and wrap modulo 2^`WORD_SIZE. Overflow is computed locally from sign bits, with m = MSB:
  - ADD: ovf = (a[m]==b[m]) && (c[m]!=a[m]).
  - SUB: ovf = (a[m]!=b[m]) && (c[m]!=a[m]).
- Saturation, when SATURATE=1 and ovf=1: out_result = a[m] ? min negative : max positive. out_overflow stays 1.
- Sticky overflow:
  - sticky_ovf is set in the cycle after s2_load of an overflowing result.
  - ovf_clr clears it.
  - If set and clear fall in the same cycle, set wins.
- op_count increments on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - Accept and output handshake in the same cycle with both stages full: S2 takes the S1 data and S1 takes the new request. Occupancy is unchanged.

Decomposition:
- The shared header (top_macro.vh) holds:
  - `WORD_SIZE;
  - ALU mode codes ALU_ADD=0 and ALU_SUB=1, moved out of alu's local params so both blocks share them.
- One natural sub-module: alu, instantiated once for the sum/difference c.
- Overflow and saturation logic stays local to alu_issue.

Test Plan:
(Values are for a WORD_SIZE=8 build, SATURATE=0 unless stated.)
1. Single op: a=5, b=3, ADD, tag=2, out_ready=1 -> out_valid 2 cycles later; result=8, overflow=0, tag=2; op_count=1.
2. Overflow corners:
   - 127+1 ADD -> -128, ovf=1.
   - 0-(-128) SUB -> -128, ovf=1.
   - -128+(-1) ADD -> 127, ovf=1.
   - 0-0 SUB -> 0, ovf=0.
   - sticky_ovf=1 after the first overflowing op; ovf_clr pulsed in the same cycle as a new overflow -> sticky stays 1.
3. SATURATE=1:
   - 100+100 ADD -> 127, ovf=1.
   - -100-100 SUB -> -128, ovf=1.
   - 50+20 -> 70, ovf=0.
4. Backpressure: 6 back-to-back requests, out_ready held 0 for 5 cycles -> in_ready drops after 2 accepts; outputs stable while stalled; after release all 6 results return in order with correct tags; op_count=6.
5. Streaming: in_valid and out_ready both held 1 for 20 cycles with random operands -> one result per cycle after 2-cycle fill; results match the reference model; op_count wraps correctly with CNT_W=4.
6. Reset mid-flight: assert rst_n=0 asynchronously with 2 ops in flight -> out_valid, sticky_ovf and op_count are 0 immediately; after release the first new request completes normally.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared word size, alu mode codes and operand payload for the alu issue slice.
package alu_issue_pkg;

   localparam int unsigned WORD_SIZE = 8;

   typedef logic signed [WORD_SIZE-1:0] word_t;

   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_SUB = 1'b1
   } alu_mode_e;

   typedef struct packed {
      word_t     a;
      word_t     b;
      alu_mode_e mode;
   } alu_op_t;

   localparam word_t WORD_MAX = word_t'({1'b0, {(WORD_SIZE-1){1'b1}}});
   localparam word_t WORD_MIN = word_t'({1'b1, {(WORD_SIZE-1){1'b0}}});

   // Clamp value for an overflowed result; direction follows the sign of operand a.
   function automatic word_t sat_word(input logic neg);
      return neg ? WORD_MIN : WORD_MAX;
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request and result handshakes between issue logic and writeback.
interface alu_issue_if
   import alu_issue_pkg::*;
#(
   parameter int unsigned TAG_W = 4
) ();

   logic             in_valid;
   logic             in_ready;
   word_t            in_a;
   word_t            in_b;
   logic             in_mode;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   word_t            out_result;
   logic             out_overflow;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_tag
   );

endinterface

// File: rtl/alu_issue_alu.sv
// Combinational add/subtract core; wraps modulo 2^WORD_SIZE.
module alu_issue_alu
   import alu_issue_pkg::*;
(
   input  word_t     a,
   input  word_t     b,
   input  alu_mode_e mode,
   output word_t     c_c
);

   // sum or difference of the two operands
   always_comb begin
      c_c = (mode == ALU_SUB) ? (a - b) : (a + b);
   end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue front end for the alu: operand register, result register,
// sticky overflow status and a completion counter.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_if.slave       io,
   input  logic             ovf_clr,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] op_count
);

   localparam int unsigned MSB = WORD_SIZE - 1;

   logic             s1_valid;
   alu_op_t          s1_op;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_valid;
   word_t            s2_result;
   logic             s2_ovf;
   logic [TAG_W-1:0] s2_tag;

   logic             s2_load_c;
   logic             in_ready_c;
   logic             accept_c;
   logic             out_hs_c;
   logic             ovf_c;
   word_t            sum_c;
   word_t            res_c;

   alu_issue_alu u_alu (
      .a    (s1_op.a),
      .b    (s1_op.b),
      .mode (s1_op.mode),
      .c_c  (sum_c)
   );

   // stage advance and handshake qualifiers
   always_comb begin
      s2_load_c  = s1_valid && (!s2_valid || io.out_ready);
      in_ready_c = !s1_valid || s2_load_c;
      accept_c   = io.in_valid && in_ready_c;
      out_hs_c   = s2_valid && io.out_ready;
   end

   // overflow from operand/result sign bits, optional clamp
   always_comb begin
      if (s1_op.mode == ALU_SUB) begin
         ovf_c = (s1_op.a[MSB] != s1_op.b[MSB]) && (sum_c[MSB] != s1_op.a[MSB]);
      end else begin
         ovf_c = (s1_op.a[MSB] == s1_op.b[MSB]) && (sum_c[MSB] != s1_op.a[MSB]);
      end
      res_c = sum_c;
      if ((SATURATE != 0) && ovf_c) begin
         res_c = sat_word(s1_op.a[MSB]);
      end
   end

   // S1: operand register, loaded on accept, emptied when it drains to S2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_tag   <= '0;
      end else if (accept_c) begin
         s1_valid   <= 1'b1;
         s1_op.a    <= io.in_a;
         s1_op.b    <= io.in_b;
         s1_op.mode <= alu_mode_e'(io.in_mode);
         s1_tag     <= io.in_tag;
      end else if (s2_load_c) begin
         s1_valid <= 1'b0;
      end
   end

   // S2: result register, held stable while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_ovf    <= 1'b0;
         s2_tag    <= '0;
      end else if (s2_load_c) begin
         s2_valid  <= 1'b1;
         s2_result <= res_c;
         s2_ovf    <= ovf_c;
         s2_tag    <= s1_tag;
      end else if (out_hs_c) begin
         s2_valid <= 1'b0;
      end
   end

   // sticky overflow (a new overflow beats a clear) and completion counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
         op_count   <= '0;
      end else begin
         if (s2_load_c && ovf_c) begin
            sticky_ovf <= 1'b1;
         end else if (ovf_clr) begin
            sticky_ovf <= 1'b0;
         end
         if (out_hs_c) begin
            op_count <= op_count + CNT_W'(1);
         end
      end
   end

   assign io.in_ready     = in_ready_c;
   assign io.out_valid    = s2_valid;
   assign io.out_result   = s2_result;
   assign io.out_overflow = s2_ovf;
   assign io.out_tag      = s2_tag;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a wrapping/4-bit-counter instance and a saturating
// instance share the same stimulus and are checked against one queue model.
module tb_alu_issue;
   import alu_issue_pkg::*;

   localparam int unsigned TAG_W = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ovf_clr;
   logic       sticky0;
   logic       sticky1;
   logic [3:0] cnt0;
   logic [7:0] cnt1;

   alu_issue_if #(.TAG_W(TAG_W)) if0 ();
   alu_issue_if #(.TAG_W(TAG_W)) if1 ();

   assign if1.in_valid  = if0.in_valid;
   assign if1.in_a      = if0.in_a;
   assign if1.in_b      = if0.in_b;
   assign if1.in_mode   = if0.in_mode;
   assign if1.in_tag    = if0.in_tag;
   assign if1.out_ready = if0.out_ready;

   alu_issue #(.TAG_W(TAG_W), .CNT_W(4), .SATURATE(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (if0.slave),
      .ovf_clr    (ovf_clr),
      .sticky_ovf (sticky0),
      .op_count   (cnt0)
   );

   alu_issue #(.TAG_W(TAG_W), .CNT_W(8), .SATURATE(1)) dut_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (if1.slave),
      .ovf_clr    (ovf_clr),
      .sticky_ovf (sticky1),
      .op_count   (cnt1)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int     a;
      int     b;
      bit     mode;
      int     tag;
      longint acc;
      bit     seen;
   } ent_t;

   typedef struct {
      int a;
      int b;
      bit mode;
      int tag;
      int res;
      bit ovf;
      int sres;
   } vec_t;

   ent_t   q[$];
   longint cyc = 0;
   int     m_cnt = 0;
   bit     m_sticky = 1'b0;

   bit s_valid, s_acc, s_hs;
   int s_res, s_sres, s_ovf, s_tag;

   // exact arithmetic on ints; overflow means the true value leaves [-128,127]
   function automatic int full_of(input ent_t e);
      return e.mode ? (e.a - e.b) : (e.a + e.b);
   endfunction

   function automatic bit ovf_of(input int f);
      return (f > 127) || (f < -128);
   endfunction

   function automatic int wrap_of(input int f);
      int w;
      w = f % 256;
      if (w > 127) w = w - 256;
      if (w < -128) w = w + 256;
      return w;
   endfunction

   function automatic int sat_of(input int f);
      return (f > 127) ? 127 : ((f < -128) ? -128 : f);
   endfunction

   task automatic chk(input string name, input integer act, input integer exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input int a, input int b, input bit mode,
                        input int tag, input bit ordy, input bit clr);
      if0.in_valid  = v;
      if0.in_a      = WORD_SIZE'(a);
      if0.in_b      = WORD_SIZE'(b);
      if0.in_mode   = mode;
      if0.in_tag    = TAG_W'(tag);
      if0.out_ready = ordy;
      ovf_clr       = clr;
   endtask

   // Called at a falling edge with inputs set: checks both DUTs, advances the model one clock.
   task automatic step();
      bit   exp_rdy, ev, clr, set;
      ent_t e, h;
      int   f;
      #1;
      exp_rdy = (q.size() < 2) || if0.out_ready;
      ev = (q.size() > 0) && (q[0].acc + 2 <= cyc);
      chk("in_ready", if0.in_ready, exp_rdy);
      chk("in_ready_sat", if1.in_ready, exp_rdy);
      chk("out_valid", if0.out_valid, ev);
      chk("out_valid_sat", if1.out_valid, ev);
      if (ev) begin
         h = q[0];
         f = full_of(h);
         chk("result", if0.out_result, wrap_of(f));
         chk("overflow", if0.out_overflow, ovf_of(f));
         chk("tag", if0.out_tag, h.tag);
         chk("result_sat", if1.out_result, sat_of(f));
         chk("overflow_sat", if1.out_overflow, ovf_of(f));
         chk("tag_sat", if1.out_tag, h.tag);
      end
      chk("op_count", cnt0, m_cnt % 16);
      chk("op_count_sat", cnt1, m_cnt % 256);
      chk("sticky", sticky0, m_sticky);
      chk("sticky_sat", sticky1, m_sticky);
      s_valid = if0.out_valid;
      s_res   = if0.out_result;
      s_sres  = if1.out_result;
      s_ovf   = int'(if0.out_overflow);
      s_tag   = int'(if0.out_tag);
      s_acc   = if0.in_valid && exp_rdy;
      s_hs    = ev && if0.out_ready;
      clr     = ovf_clr;
      e = '{a: int'(if0.in_a), b: int'(if0.in_b), mode: if0.in_mode,
            tag: int'(if0.in_tag), acc: cyc, seen: 1'b0};
      @(posedge clk);
      cyc++;
      if (s_hs) begin
         void'(q.pop_front());
         m_cnt++;
      end
      if (s_acc) q.push_back(e);
      set = 1'b0;
      if ((q.size() > 0) && !q[0].seen && (q[0].acc + 2 <= cyc)) begin
         q[0].seen = 1'b1;
         set = ovf_of(full_of(q[0]));
      end
      m_sticky = set ? 1'b1 : (clr ? 1'b0 : m_sticky);
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 0, 0, 1'b0, 0, ordy, 1'b0);
         step();
      end
   endtask

   // Steps with out_ready=1 until a result is seen; lat counts cycles after the accept.
   task automatic wait_result(output int lat);
      lat = 0;
      s_valid = 1'b0;
      while (!s_valid && lat < 6) begin
         drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
         step();
         lat++;
      end
   endtask

   vec_t vt[8];
   int   pa[6], pb[6];
   bit   pm[6];

   initial begin
      int   lat, acc_n, hold_res, hold_tag, n_out;
      int   ret_tags[$];
      logic [7:0] base;

      vt[0] = '{a: 5,    b: 3,    mode: 1'b0, tag: 2, res: 8,    ovf: 1'b0, sres: 8};
      vt[1] = '{a: 127,  b: 1,    mode: 1'b0, tag: 3, res: -128, ovf: 1'b1, sres: 127};
      vt[2] = '{a: 0,    b: -128, mode: 1'b1, tag: 4, res: -128, ovf: 1'b1, sres: 127};
      vt[3] = '{a: -128, b: -1,   mode: 1'b0, tag: 5, res: 127,  ovf: 1'b1, sres: -128};
      vt[4] = '{a: 0,    b: 0,    mode: 1'b1, tag: 6, res: 0,    ovf: 1'b0, sres: 0};
      vt[5] = '{a: 100,  b: 100,  mode: 1'b0, tag: 7, res: -56,  ovf: 1'b1, sres: 127};
      vt[6] = '{a: -100, b: 100,  mode: 1'b1, tag: 8, res: 56,   ovf: 1'b1, sres: -128};
      vt[7] = '{a: 50,   b: 20,   mode: 1'b0, tag: 9, res: 70,   ovf: 1'b0, sres: 70};

      // reset state
      rst_n = 1'b0;
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_out_valid", if0.out_valid, 0);
      chk("rst_out_result", if0.out_result, 0);
      chk("rst_out_overflow", if0.out_overflow, 0);
      chk("rst_out_tag", if0.out_tag, 0);
      chk("rst_sticky", sticky0, 0);
      chk("rst_op_count", cnt0, 0);
      chk("rst_in_ready", if0.in_ready, 1);
      rst_n = 1'b1;

      // directed vectors, one at a time
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vt[i].a, vt[i].b, vt[i].mode, vt[i].tag, 1'b1, 1'b0);
         step();
         wait_result(lat);
         chk($sformatf("tv%0d_latency", i), lat, 2);
         chk($sformatf("tv%0d_result", i), s_res, vt[i].res);
         chk($sformatf("tv%0d_ovf", i), s_ovf, vt[i].ovf);
         chk($sformatf("tv%0d_tag", i), s_tag, vt[i].tag);
         chk($sformatf("tv%0d_sat_result", i), s_sres, vt[i].sres);
         if (i == 0) chk("op_count_first", cnt0, 1);
         if (i == 1) chk("sticky_first", sticky0, 1);
      end

      // sticky: clear alone, then clear coinciding with a new overflow
      drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
      step();
      chk("sticky_cleared", sticky0, 0);
      drive(1'b1, 127, 1, 1'b0, 10, 1'b1, 1'b0);
      step();
      drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1);
      step();
      chk("sticky_set_wins", sticky0, 1);
      idle(1'b1, 3);

      // backpressure: 6 requests, consumer stalled for 5 cycles
      base = cnt1;
      for (int i = 0; i < 6; i++) begin
         pa[i] = int'($urandom_range(255)) - 128;
         pb[i] = int'($urandom_range(255)) - 128;
         pm[i] = 1'($urandom_range(1));
      end
      acc_n = 0;
      hold_res = 0;
      hold_tag = 0;
      for (int c = 0; c < 5; c++) begin
         drive(acc_n < 6, pa[acc_n], pb[acc_n], pm[acc_n], acc_n, 1'b0, 1'b0);
         step();
         if (s_acc) acc_n++;
         if (c == 2) begin
            hold_res = s_res;
            hold_tag = s_tag;
         end
      end
      chk("bp_accepts", acc_n, 2);
      chk("bp_hold_result", s_res, hold_res);
      chk("bp_hold_tag", s_tag, hold_tag);
      for (int c = 0; c < 30 && (acc_n < 6 || q.size() > 0); c++) begin
         drive(acc_n < 6, pa[acc_n % 6], pb[acc_n % 6], pm[acc_n % 6], acc_n, 1'b1, 1'b0);
         step();
         if (s_acc) acc_n++;
         if (s_hs) ret_tags.push_back(s_tag);
      end
      chk("bp_returned", ret_tags.size(), 6);
      for (int i = 0; i < ret_tags.size(); i++) chk($sformatf("bp_order%0d", i), ret_tags[i], i);
      chk("bp_op_count", 8'(cnt1 - base), 6);

      // streaming: full throughput for 20 cycles
      n_out = 0;
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
               1'($urandom_range(1)), int'($urandom_range(15)), 1'b1, 1'b0);
         step();
         if (s_valid) n_out++;
      end
      chk("stream_results", n_out, 18);
      idle(1'b1, 4);

      // random traffic, backpressure and clears
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(1)), int'($urandom_range(255)) - 128,
               int'($urandom_range(255)) - 128, 1'($urandom_range(1)),
               int'($urandom_range(15)), ($urandom_range(3) != 0),
               ($urandom_range(7) == 0));
         step();
      end
      idle(1'b1, 4);

      // asynchronous reset with two operations in flight
      drive(1'b1, 127, 1, 1'b0, 1, 1'b0, 1'b0);
      step();
      drive(1'b1, 3, 4, 1'b0, 2, 1'b0, 1'b0);
      step();
      chk("pre_reset_valid", if0.out_valid, 1);
      chk("pre_reset_sticky", sticky0, 1);
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", if0.out_valid, 0);
      chk("mid_rst_out_valid_sat", if1.out_valid, 0);
      chk("mid_rst_sticky", sticky0, 0);
      chk("mid_rst_sticky_sat", sticky1, 0);
      chk("mid_rst_op_count", cnt0, 0);
      chk("mid_rst_op_count_sat", cnt1, 0);
      chk("mid_rst_out_result", if0.out_result, 0);
      q.delete();
      m_cnt = 0;
      m_sticky = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 5, 3, 1'b0, 2, 1'b1, 1'b0);
      step();
      wait_result(lat);
      chk("post_rst_latency", lat, 2);
      chk("post_rst_result", s_res, 8);
      chk("post_rst_tag", s_tag, 2);
      idle(1'b1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
